// File: rtl/axil_uart_pkg.sv
// Shared constants and types for the AXI4-Lite UART transmit responder.
package axil_uart_pkg;

  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = 4;
  localparam int unsigned BAUD_W     = 16;

  localparam logic [1:0] TXDATA = 2'd0;
  localparam logic [1:0] STATUS = 2'd1;
  localparam logic [1:0] BAUD   = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/uart_tx_shifter.sv
// 8N1 serialiser with a valid/ready byte input; the bit period is latched at
// every bit boundary so divisor changes never stretch or cut a bit in flight.
module uart_tx_shifter
  import axil_uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BAUD_W-1:0] baud_div,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready_c,
  output logic              tx,
  output logic              busy_c
);

  tx_state_t         state;
  logic [BAUD_W-1:0] cnt;
  logic [BAUD_W-1:0] div_q;
  logic [7:0]        shreg;
  logic [2:0]        idx;
  logic              bit_end_c;

  assign bit_end_c    = (cnt == div_q);
  // Accept in IDLE, or at the end of STOP so frames run back to back.
  assign byte_ready_c = (state == IDLE) || ((state == STOP) && bit_end_c);
  assign busy_c       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      div_q <= '0;
      shreg <= '0;
      idx   <= '0;
      tx    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (byte_valid) begin
            shreg <= byte_data;
            cnt   <= '0;
            div_q <= baud_div;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end_c) begin
            cnt   <= '0;
            div_q <= baud_div;
            tx    <= shreg[0];
            idx   <= '0;
            state <= DATA;
          end else begin
            cnt <= cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end_c) begin
            cnt   <= '0;
            div_q <= baud_div;
            if (idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx    <= shreg[1];
              shreg <= {1'b0, shreg[7:1]};
              idx   <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_end_c) begin
            cnt   <= '0;
            div_q <= baud_div;
            if (byte_valid) begin
              shreg <= byte_data;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axil_uart_tx_slave.sv
// AXI4-Lite responder fronting a byte FIFO and 8N1 UART transmitter, with
// STATUS and BAUD_DIV registers for firmware polling.
module axil_uart_tx_slave
  import axil_uart_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 8,
  parameter logic [BAUD_W-1:0] DIV_RESET  = 16'd433,
  parameter int unsigned       ADDR_W     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_W-1:0]     i_awaddr,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [AXI_DATA_W-1:0] i_wdata,
  input  logic [AXI_STRB_W-1:0] i_wstrb,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  input  logic [ADDR_W-1:0]     i_araddr,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  output logic [AXI_DATA_W-1:0] o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic                  o_uart_tx,
  output logic                  o_tx_irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [CNT_W-1:0]  wr_ptr, rd_ptr, fifo_count_c;
  logic              fifo_empty_c, fifo_full_c;
  logic              push_c, pop_c, byte_ready_c, busy_c;

  logic              aw_held, w_held, wr_fire_c;
  logic [1:0]        aw_off;
  logic [15:0]       w_data;
  logic [1:0]        w_strb;
  logic [1:0]        wr_resp_c;
  logic [BAUD_W-1:0] baud_div;

  logic [AXI_DATA_W-1:0] rd_data_c;
  logic [1:0]            rd_resp_c;
  logic                  unused_c;

  assign unused_c = ^{i_awaddr, i_araddr, i_wdata[31:16], i_wstrb[3:2]};

  // Extra pointer MSB distinguishes full from empty.
  assign fifo_count_c = wr_ptr - rd_ptr;
  assign fifo_empty_c = (wr_ptr == rd_ptr);
  assign fifo_full_c  = (fifo_count_c == CNT_W'(FIFO_DEPTH));

  assign wr_fire_c = aw_held && w_held;
  assign push_c    = wr_fire_c && (aw_off == TXDATA) && w_strb[0] && !fifo_full_c;
  assign pop_c     = !fifo_empty_c && byte_ready_c;

  always_comb begin
    wr_resp_c = RESP_OKAY;
    if (aw_off == 2'd3) wr_resp_c = RESP_SLVERR;
    else if ((aw_off == TXDATA) && w_strb[0] && fifo_full_c) wr_resp_c = RESP_SLVERR;
  end

  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    case (i_araddr[3:2])
      STATUS:  rd_data_c = {19'd0, 5'(fifo_count_c), 5'd0, fifo_empty_c, fifo_full_c, busy_c};
      BAUD:    rd_data_c = {16'd0, baud_div};
      2'd3:    rd_resp_c = RESP_SLVERR;
      default: rd_data_c = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_awready <= 1'b1;
      o_wready  <= 1'b1;
      o_arready <= 1'b1;
      o_bvalid  <= 1'b0;
      o_rvalid  <= 1'b0;
      o_bresp   <= RESP_OKAY;
      o_rresp   <= RESP_OKAY;
      o_rdata   <= '0;
      o_tx_irq  <= 1'b1;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_off    <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      baud_div  <= DIV_RESET;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      // AW and W are captured independently and held until the write fires.
      if (i_awvalid && o_awready) begin
        o_awready <= 1'b0;
        aw_held   <= 1'b1;
        aw_off    <= i_awaddr[3:2];
      end
      if (i_wvalid && o_wready) begin
        o_wready <= 1'b0;
        w_held   <= 1'b1;
        w_data   <= i_wdata[15:0];
        w_strb   <= i_wstrb[1:0];
      end
      if (wr_fire_c) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        o_bvalid <= 1'b1;
        o_bresp  <= wr_resp_c;
        if (aw_off == BAUD) begin
          if (w_strb[0]) baud_div[7:0]  <= w_data[7:0];
          if (w_strb[1]) baud_div[15:8] <= w_data[15:8];
        end
      end
      if (o_bvalid && i_bready) begin
        o_bvalid  <= 1'b0;
        o_awready <= 1'b1;
        o_wready  <= 1'b1;
      end

      if (push_c) begin
        fifo_mem[wr_ptr[PTR_W-1:0]] <= w_data[7:0];
        wr_ptr <= wr_ptr + CNT_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + CNT_W'(1);

      if (i_arvalid && o_arready) begin
        o_arready <= 1'b0;
        o_rvalid  <= 1'b1;
        o_rdata   <= rd_data_c;
        o_rresp   <= rd_resp_c;
      end else if (o_rvalid && i_rready) begin
        o_rvalid  <= 1'b0;
        o_arready <= 1'b1;
      end

      o_tx_irq <= fifo_empty_c && !busy_c;
    end
  end

  uart_tx_shifter u_shifter (
    .clk          (i_clk),
    .rst          (i_rst),
    .baud_div     (baud_div),
    .byte_valid   (!fifo_empty_c),
    .byte_data    (fifo_mem[rd_ptr[PTR_W-1:0]]),
    .byte_ready_c (byte_ready_c),
    .tx           (o_uart_tx),
    .busy_c       (busy_c)
  );

endmodule
